// File: rtl/d_color_pkg.sv
// -----------------------------------------------------------------------------
// d_color_pkg
// Shared definitions for the pixel colour path (d_hsv2rgb / d_rgb2hsv).
//   - Hue encoding: six BIN_W-wide bins, red at 0, green at HUE_G_BASE and
//     blue at HUE_B_BASE. Hue wraps naturally at 256.
//   - Pixel field slicing: RGB and HSV pixels are 24-bit packed structs with
//     the first channel in the top byte.
//   - FSM state and max-channel encodings used by d_rgb2hsv.
// -----------------------------------------------------------------------------
package d_color_pkg;

   localparam int BIN_W      = 43;
   localparam int HUE_G_BASE = 2 * BIN_W;  // 86
   localparam int HUE_B_BASE = 4 * BIN_W;  // 172
   localparam int DIV_W      = 16;

   // {R[23:16], G[15:8], B[7:0]}
   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgbT;

   // {H[23:16], S[15:8], V[7:0]}
   typedef struct packed {
      logic [7:0] h;
      logic [7:0] s;
      logic [7:0] v;
   } hsvT;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PREP = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } stateT;

   typedef enum logic [1:0] {
      MAX_R = 2'd0,
      MAX_G = 2'd1,
      MAX_B = 2'd2
   } maxSelT;

endpackage : d_color_pkg

// File: rtl/d_divider_seq.sv
// -----------------------------------------------------------------------------
// d_divider_seq
// Unsigned restoring divider, one quotient bit per clock, DIV_W iterations.
// Operands are captured on start; done pulses for one cycle once the last
// iteration has been written, and quotient is valid from then until the
// next start. Quotients wider than 8 bits saturate to 255 (this includes
// divide-by-zero, which produces an all-ones quotient).
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start            load operands and begin a division
//   dividend[15:0]   unsigned dividend
//   divisor[7:0]     unsigned divisor
//   busy             iterations in progress
//   done             one-cycle pulse after the final iteration
//   quotient[7:0]    saturated floor(dividend / divisor)
// -----------------------------------------------------------------------------
module d_divider_seq
   import d_color_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] dividend,
   input  logic [7:0]  divisor,
   output logic        busy,
   output logic        done,
   output logic [7:0]  quotient
);

   localparam int CNT_W = $clog2(DIV_W + 1);

   // quo starts as the dividend and is shifted left one bit per iteration;
   // quotient bits enter at the bottom as dividend bits leave the top.
   logic [DIV_W-1:0] quo;
   logic [7:0]       rem;
   logic [7:0]       dvsr;
   logic [CNT_W-1:0] cnt;
   logic [8:0]       remShift;
   logic [8:0]       remDiff;
   logic             fits;

   // remShift is 9 bits because the shifted remainder can reach 2*dvsr-1.
   always_comb begin
      remShift = {rem, quo[DIV_W-1]};
      remDiff  = remShift - {1'b0, dvsr};
      fits     = (remShift >= {1'b0, dvsr});
   end

   // NOTE: state registers are written with non-blocking assignments so every
   // flop samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         quo  <= '0;
         rem  <= '0;
         dvsr <= '0;
         cnt  <= '0;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            quo  <= dividend;
            rem  <= '0;
            dvsr <= divisor;
            cnt  <= CNT_W'(DIV_W);
            busy <= 1'b1;
         end else if (busy) begin
            // When the trial subtraction fails, remShift < dvsr <= 255, so
            // its top bit is zero and dropping it is lossless.
            rem  <= fits ? remDiff[7:0] : remShift[7:0];
            quo  <= {quo[DIV_W-2:0], fits};
            cnt  <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

   assign quotient = (|quo[DIV_W-1:8]) ? 8'hFF : quo[7:0];

endmodule : d_divider_seq

// File: rtl/d_rgb2hsv.sv
// -----------------------------------------------------------------------------
// d_rgb2hsv
// Converts one 24-bit RGB pixel to packed 8-bit HSV through a valid/ready
// handshake. Sequence: IDLE (accept) -> PREP (max/min, operands) -> DIV
// (two lockstep sequential dividers for S and H) -> DONE (hold result).
// Output appears 18 cycles after the acceptance edge; no overlap between
// pixels.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid     tRGB is valid
//   in_ready     block can accept a pixel (high only in IDLE)
//   tRGB[23:0]   {R,G,B}
//   out_valid    tHSV is valid (high only in DONE)
//   out_ready    downstream accepts tHSV
//   tHSV[23:0]   {H,S,V}
// -----------------------------------------------------------------------------
module d_rgb2hsv
   import d_color_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [23:0] tRGB,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [23:0] tHSV
);

   stateT       state;
   stateT       nextState;
   rgbT         pix;
   hsvT         hsvReg;

   maxSelT      maxSel;
   logic [7:0]  maxVal;
   logic [7:0]  minVal;
   logic [7:0]  delta;
   logic signed [8:0] hueNum;
   logic [7:0]  hueAbs;
   logic [7:0]  hueBase;
   logic [15:0] sDividend;
   logic [15:0] hDividend;

   logic        startDiv;
   logic        sBusy, sDone, hBusy, hDone;
   logic [7:0]  sQuot, hQuot;
   logic        divFinished;
   logic [7:0]  hueFinal;
   logic [7:0]  satFinal;

   // The latched pixel stays stable until the next acceptance, so the
   // operand logic below is valid in PREP and still valid when the
   // quotients are folded into the result at the end of DIV.
   always_comb begin
      // NOTE: every signal gets a default before any branch so no path leaves
      // it unassigned, which would otherwise infer a latch.
      maxSel  = MAX_R;
      maxVal  = pix.r;
      minVal  = pix.r;
      hueNum  = '0;
      hueBase = 8'd0;

      // Tie priority R > G > B for the max channel.
      if (pix.r >= pix.g && pix.r >= pix.b) begin
         maxSel = MAX_R;
         maxVal = pix.r;
      end else if (pix.g >= pix.b) begin
         maxSel = MAX_G;
         maxVal = pix.g;
      end else begin
         maxSel = MAX_B;
         maxVal = pix.b;
      end

      if (pix.g < minVal) minVal = pix.g;
      if (pix.b < minVal) minVal = pix.b;

      case (maxSel)
         MAX_R: begin
            hueNum  = $signed({1'b0, pix.g}) - $signed({1'b0, pix.b});
            hueBase = 8'd0;
         end
         MAX_G: begin
            hueNum  = $signed({1'b0, pix.b}) - $signed({1'b0, pix.r});
            hueBase = 8'(HUE_G_BASE);
         end
         MAX_B: begin
            hueNum  = $signed({1'b0, pix.r}) - $signed({1'b0, pix.g});
            hueBase = 8'(HUE_B_BASE);
         end
         default: begin
            hueNum  = '0;
            hueBase = 8'd0;
         end
      endcase
   end

   always_comb begin
      delta     = maxVal - minVal;
      // |hueNum| <= 255, so the magnitude fits in 8 bits.
      hueAbs    = hueNum[8] ? 8'(-hueNum) : hueNum[7:0];
      sDividend = 16'(delta) * 16'd255;
      hDividend = 16'(hueAbs) * 16'(BIN_W);
   end

   assign startDiv = (state == PREP);

   d_divider_seq uSatDiv (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (startDiv),
      .dividend (sDividend),
      .divisor  (maxVal),
      .busy     (sBusy),
      .done     (sDone),
      .quotient (sQuot)
   );

   d_divider_seq uHueDiv (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (startDiv),
      .dividend (hDividend),
      .divisor  (delta),
      .busy     (hBusy),
      .done     (hDone),
      .quotient (hQuot)
   );

   assign divFinished = sDone && hDone && !sBusy && !hBusy;

   // Zero max / zero delta bypass the (meaningless) divider results. The
   // hue add/subtract wraps mod 256 by plain 8-bit truncation.
   always_comb begin
      satFinal = (maxVal == 8'd0) ? 8'd0 : sQuot;
      if (delta == 8'd0)
         hueFinal = 8'd0;
      else if (hueNum[8])
         hueFinal = hueBase - hQuot;
      else
         hueFinal = hueBase + hQuot;
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE: if (in_valid) nextState = PREP;
         PREP: nextState = DIV;
         DIV:  if (divFinished) nextState = DONE;
         DONE: if (out_ready) nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         pix    <= '0;
         hsvReg <= '0;
      end else begin
         state <= nextState;
         if (state == IDLE && in_valid)
            pix <= rgbT'(tRGB);
         if (state == DIV && divFinished)
            hsvReg <= '{h: hueFinal, s: satFinal, v: maxVal};
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign tHSV      = hsvReg;

endmodule : d_rgb2hsv

// File: tb/tb_d_rgb2hsv.sv
// -----------------------------------------------------------------------------
// tb_d_rgb2hsv
// Directed vectors with hand-computed HSV results, latency, backpressure and
// mid-division reset for d_rgb2hsv. Signals are driven and sampled 1 ns after
// the rising edge.
// -----------------------------------------------------------------------------
module tb_d_rgb2hsv;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [23:0] tRGB;
   logic        out_valid;
   logic        out_ready;
   logic [23:0] tHSV;

   int total = 0;
   int bad   = 0;

   d_rgb2hsv dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .tRGB      (tRGB),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .tHSV      (tHSV)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a pixel and return just after the edge that accepted it.
   task automatic acceptPixel(input string tag, input logic [23:0] rgb);
      bit seen;
      seen     = 1'b0;
      in_valid = 1'b1;
      tRGB     = rgb;
      for (int i = 0; i < 60; i++) begin
         if (in_ready) begin
            seen = 1'b1;
            break;
         end
         step();
      end
      check({tag, "_in_ready"}, 32'(seen), 32'd1);
      step();
      in_valid = 1'b0;
   endtask

   // Count edges from acceptance to out_valid and compare the result.
   task automatic waitResult(input string tag, input logic [23:0] expHsv);
      int lat;
      lat = 0;
      for (int i = 1; i <= 40; i++) begin
         step();
         if (out_valid) begin
            lat = i;
            break;
         end
      end
      check({tag, "_latency"}, 32'(lat), 32'd18);
      check({tag, "_hsv"}, 32'(tHSV), 32'(expHsv));
   endtask

   task automatic handshake(input string tag);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
      check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
   endtask

   task automatic pixel(input string tag, input logic [23:0] rgb, input logic [23:0] expHsv);
      acceptPixel(tag, rgb);
      waitResult(tag, expHsv);
      handshake(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [23:0] heldHsv;
      int          sawValid;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      tRGB      = '0;
      #12;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_hsv", 32'(tHSV), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Primaries, secondaries, bypasses, mid-tone.
      pixel("red",     24'hFF0000, 24'h00FFFF);
      pixel("green",   24'h00FF00, 24'h56FFFF);
      pixel("blue",    24'h0000FF, 24'hACFFFF);
      pixel("yellow",  24'hFFFF00, 24'h2BFFFF);
      pixel("magenta", 24'hFF00FF, 24'hD5FFFF);
      pixel("gray",    24'h808080, 24'h000080);
      pixel("black",   24'h000000, 24'h000000);
      pixel("mid",     24'hC86432, 24'h0EBFC8);
      // Cyan: G/B tie -> G max, num = B-R = 255, q = 43, H = 86+43 = 129.
      pixel("cyan",    24'h00FFFF, 24'h81FFFF);

      // out_ready high before DONE: handshake completes on the edge after
      // out_valid rises.
      out_ready = 1'b1;
      acceptPixel("early", 24'hFF0000);
      waitResult("early", 24'h00FFFF);
      step();
      check("early_valid_drop", 32'(out_valid), 32'd0);
      check("early_ready_back", 32'(in_ready), 32'd1);
      out_ready = 1'b0;

      // Backpressure: hold the result for 10 cycles while a second pixel
      // waits on in_valid.
      acceptPixel("bp_a", 24'hC86432);
      waitResult("bp_a", 24'h0EBFC8);
      heldHsv  = tHSV;
      in_valid = 1'b1;
      tRGB     = 24'h0000FF;
      for (int i = 0; i < 10; i++) begin
         step();
         check("bp_hold_valid", 32'(out_valid), 32'd1);
         check("bp_hold_hsv", 32'(tHSV), 32'h0EBFC8);
         check("bp_hold_busy", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("bp_valid_drop", 32'(out_valid), 32'd0);
      check("bp_ready_back", 32'(in_ready), 32'd1);
      // in_valid still high: the second pixel is taken on the next edge.
      step();
      in_valid = 1'b0;
      check("bp_b_taken", 32'(in_ready), 32'd0);
      waitResult("bp_b", 24'hACFFFF);
      handshake("bp_b");

      // Reset in the middle of division: nothing comes out for that pixel.
      acceptPixel("abort", 24'hFFFF00);
      repeat (9) step();
      rst_n = 1'b0;
      #1;
      check("abort_valid", 32'(out_valid), 32'd0);
      check("abort_hsv", 32'(tHSV), 32'd0);
      #3;
      rst_n = 1'b1;
      step();
      check("abort_in_ready", 32'(in_ready), 32'd1);
      sawValid = 0;
      for (int i = 0; i < 25; i++) begin
         step();
         if (out_valid) sawValid++;
      end
      check("abort_no_output", 32'(sawValid), 32'd0);
      pixel("post_rst", 24'h00FF00, 24'h56FFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_d_rgb2hsv
